// File: rtl/i2c_master.sv
// Bus-attached I2C master: one byte per command with optional START/STOP framing.
// SCL/SDA are open-drain; the *_drv outputs are pull-low enables for the top-level pads.
module i2c_master #(
  parameter int clock_freq = 50_000_000,
  parameter int i2c_freq   = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        scl_drv,
  output logic        sda_drv,
  input  logic        sda_in
);

  localparam int Q  = clock_freq / (4 * i2c_freq);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic        busy_q, busy_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [7:0]  rx_q, rx_d;
  logic        nack_q, nack_d;
  logic [7:0]  tx_q, tx_d;
  logic        stop_q, stop_d;
  logic        rd_q, rd_d;
  logic        mnack_q, mnack_d;

  logic        cmd_accept;
  logic        quarter_end;
  logic        quarter_start;
  logic [2:0]  bit_idx;
  logic        unused_data_in;

  assign unused_data_in = ^data_in[31:12];
  assign cmd_accept     = stb & we & ~addr & ~busy_q;
  assign quarter_end    = (cnt_q == CW'(Q - 1));
  assign quarter_start  = (cnt_q == '0);
  assign bit_idx        = 3'd7 - bit_q[2:0];

  assign ack      = stb;
  assign scl_drv  = scl_q;
  assign sda_drv  = sda_q;
  assign data_out = addr ? {30'b0, nack_q, busy_q} : {23'b0, nack_q, rx_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    rx_d    = rx_q;
    nack_d  = nack_q;
    tx_d    = tx_q;
    stop_d  = stop_q;
    rd_d    = rd_q;
    mnack_d = mnack_q;

    // Quarter timer and phase advance; both wrap to 0 exactly when a state is entered.
    if (state_q != IDLE) begin
      cnt_d = quarter_end ? '0 : cnt_q + CW'(1);
      if (quarter_end) phase_d = phase_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 2'd0;
        if (cmd_accept) begin
          tx_d    = data_in[7:0];
          stop_d  = data_in[9];
          rd_d    = data_in[10];
          mnack_d = data_in[11];
          busy_d  = 1'b1;
          bit_d   = 4'd0;
          state_d = data_in[8] ? START : BIT;
        end
      end
      START: begin
        if (quarter_start) begin
          case (phase_q)
            2'd0: sda_d = 1'b0;
            2'd1: scl_d = 1'b0;
            2'd2: sda_d = 1'b1;
            default: scl_d = 1'b1;
          endcase
        end
        if (quarter_end && phase_q == 2'd3) state_d = BIT;
      end
      BIT: begin
        if (quarter_start) begin
          case (phase_q)
            2'd0: sda_d = (bit_q == 4'd8) ? (rd_q & ~mnack_q) : (~rd_q & ~tx_q[bit_idx]);
            2'd1: scl_d = 1'b0;
            2'd3: scl_d = 1'b1;
            default: ;
          endcase
        end
        // Sample at the end of the SCL-high quarter so the slave has a full quarter of setup.
        if (quarter_end && phase_q == 2'd2) begin
          if (bit_q == 4'd8) nack_d = rd_q ? mnack_q : sda_in;
          else if (rd_q)     rx_d   = {rx_q[6:0], sda_in};
        end
        if (quarter_end && phase_q == 2'd3) begin
          if (bit_q == 4'd8) begin
            if (stop_q) begin
              state_d = STOP;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (quarter_start) begin
          case (phase_q)
            2'd0: sda_d = 1'b1;
            2'd1: scl_d = 1'b0;
            2'd2: sda_d = 1'b0;
            default: ;
          endcase
        end
        if (quarter_end && phase_q == 2'd3) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          scl_d   = 1'b0;
          sda_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 2'd0;
      bit_q   <= 4'd0;
      busy_q  <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      rx_q    <= 8'd0;
      nack_q  <= 1'b0;
      tx_q    <= 8'd0;
      stop_q  <= 1'b0;
      rd_q    <= 1'b0;
      mnack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      rx_q    <= rx_d;
      nack_q  <= nack_d;
      tx_q    <= tx_d;
      stop_q  <= stop_d;
      rd_q    <= rd_d;
      mnack_q <= mnack_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a behavioural open-drain slave watches the wires, and a scoreboard
// of expected bus bytes / ack-slot levels is filled per command and drained per byte seen.
module tb_i2c_master;

  localparam int CLK_F = 2_000_000;
  localparam int I2C_F = 100_000;
  localparam int Q     = CLK_F / (4 * I2C_F);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        addr = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        ack;
  logic        scl_drv;
  logic        sda_drv;
  logic        sda_in;

  typedef struct {
    logic [7:0] bus_byte;
    logic       ack_lvl;
  } sb_t;
  sb_t sb_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic       slv_rd = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] rd_byte = 8'd0;
  logic       active = 1'b0;
  int         bit_cnt = 0;
  logic [7:0] shreg = 8'd0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  int         starts = 0;
  int         stops = 0;
  logic       slave_pull;
  logic       scl_line;
  logic       sda_line;

  i2c_master #(.clock_freq(CLK_F), .i2c_freq(I2C_F)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .scl_drv(scl_drv), .sda_drv(sda_drv), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and slave; the slave only drives while SCL is low.
  always_comb begin
    slave_pull = 1'b0;
    if (active) begin
      if (slv_rd && bit_cnt >= 0 && bit_cnt <= 7) slave_pull = ~rd_byte[3'(7 - bit_cnt)];
      else if (!slv_rd && bit_cnt == 8)          slave_pull = ack_en;
    end
  end
  assign sda_in   = ~(sda_drv | slave_pull);
  assign scl_line = ~scl_drv;
  assign sda_line = sda_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  // Slave-side protocol monitor: START/STOP detection, bit capture on SCL rise.
  always @(negedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      bit_cnt <= 0;
    end else if (scl_prev && scl_line && sda_prev && !sda_line) begin
      active  <= 1'b1;
      bit_cnt <= -1;
      starts  <= starts + 1;
    end else if (scl_prev && scl_line && !sda_prev && sda_line) begin
      active <= 1'b0;
      stops  <= stops + 1;
    end else if (!scl_prev && scl_line && active) begin
      if (bit_cnt == 8) begin
        if (sb_q.size() == 0) begin
          checkOutput("scoreboard underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          checkOutput("bus byte", {24'b0, shreg}, {24'b0, e.bus_byte});
          checkOutput("ack slot level", {31'b0, sda_line}, {31'b0, e.ack_lvl});
        end
      end
      shreg <= {shreg[6:0], sda_line};
    end else if (scl_prev && !scl_line && active) begin
      bit_cnt <= (bit_cnt >= 8) ? 0 : bit_cnt + 1;
    end
    scl_prev <= scl_line;
    sda_prev <= sda_line;
  end

  task automatic applyStimulus(input logic [11:0] cmd, input bit push,
                               input logic [7:0] exp_byte, input logic exp_ack);
    sb_t e;
    @(negedge clk);
    if (push) begin
      e.bus_byte = exp_byte;
      e.ack_lvl  = exp_ack;
      sb_q.push_back(e);
    end
    stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = {20'b0, cmd};
    #1 checkOutput("ack on write", {31'b0, ack}, 32'd1);
    @(negedge clk);
    we = 1'b0; addr = 1'b1; data_in = 32'd0;
  endtask

  // Polls status from the cycle after acceptance until busy drops; optional write while busy.
  task automatic wait_done(input string tag, input int exp_cycles, input logic [31:0] exp_last,
                           input int inj_at, input logic [11:0] inj_cmd);
    int n;
    logic [31:0] st, last;
    n = 0;
    #1 st = data_out;
    checkOutput({tag, " busy next cycle"}, {31'b0, st[0]}, 32'd1);
    last = st;
    while (st[0] && n < exp_cycles + 20) begin
      @(negedge clk);
      n++;
      if (n == inj_at) begin
        we = 1'b1; addr = 1'b0; data_in = {20'b0, inj_cmd};
      end else begin
        if (n == inj_at + 1) begin
          we = 1'b0; addr = 1'b1; data_in = 32'd0;
        end
        #1 st = data_out;
        if (st[0]) last = st;
      end
    end
    checkOutput({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
    checkOutput({tag, " last busy status"}, last, exp_last);
  endtask

  task automatic check_lines(input string tag, input logic exp_scl, input logic exp_sda);
    checkOutput({tag, " scl_drv"}, {31'b0, scl_drv}, {31'b0, exp_scl});
    checkOutput({tag, " sda_drv"}, {31'b0, sda_drv}, {31'b0, exp_sda});
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, p0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset while idle
    rst = 1'b1;
    #1 check_lines("reset", 1'b0, 1'b0);
    stb = 1'b1; addr = 1'b1;
    #1 checkOutput("reset status", data_out, 32'd0);
    checkOutput("ack follows stb high", {31'b0, ack}, 32'd1);
    addr = 1'b0;
    #1 checkOutput("reset data", data_out, 32'd0);
    stb = 1'b0;
    #1 checkOutput("ack follows stb low", {31'b0, ack}, 32'd0);
    addr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stb = 1'b1;

    // Full write transfer, slave ACKs
    ack_en = 1'b1; slv_rd = 1'b0;
    s0 = starts; p0 = stops;
    applyStimulus(12'h3A0, 1'b1, 8'hA0, 1'b0);
    wait_done("write ack", 44 * Q, 32'h1, 0, 12'h0);
    checkOutput("write ack final status", data_out, 32'h0);
    check_lines("write ack released", 1'b0, 1'b0);
    checkOutput("write ack starts", 32'(starts - s0), 32'd1);
    checkOutput("write ack stops", 32'(stops - p0), 32'd1);

    // Same transfer, slave NACKs
    ack_en = 1'b0;
    applyStimulus(12'h3A0, 1'b1, 8'hA0, 1'b1);
    wait_done("write nack", 44 * Q, 32'h3, 0, 12'h0);
    checkOutput("write nack final status", data_out, 32'h2);
    check_lines("write nack released", 1'b0, 1'b0);

    // START+write without STOP, then read without START (master NACK, STOP)
    ack_en = 1'b1;
    applyStimulus(12'h1A1, 1'b1, 8'hA1, 1'b0);
    wait_done("addr phase", 40 * Q, 32'h1, 0, 12'h0);
    check_lines("held after write", 1'b1, 1'b0);
    slv_rd = 1'b1; rd_byte = 8'h5C;
    applyStimulus(12'hE00, 1'b1, 8'h5C, 1'b1);
    wait_done("read", 40 * Q, 32'h3, 0, 12'h0);
    addr = 1'b0;
    #1 checkOutput("read data", data_out, 32'h15C);
    addr = 1'b1;
    check_lines("read released", 1'b0, 1'b0);
    slv_rd = 1'b0;

    // Command written while busy is ignored
    s0 = starts;
    applyStimulus(12'h3A0, 1'b1, 8'hA0, 1'b0);
    wait_done("busy ignore", 44 * Q, 32'h1, 10, 12'h355);
    checkOutput("busy ignore starts", 32'(starts - s0), 32'd1);
    repeat (3) @(negedge clk);
    #1 checkOutput("busy ignore stays idle", data_out, 32'h0);

    // Write without STOP then a repeated START
    applyStimulus(12'h1A0, 1'b1, 8'hA0, 1'b0);
    wait_done("pre repeat", 40 * Q, 32'h1, 0, 12'h0);
    repeat (4) @(negedge clk);
    #1 check_lines("scl held low", 1'b1, 1'b0);
    s0 = starts; p0 = stops;
    applyStimulus(12'h3A2, 1'b1, 8'hA2, 1'b0);
    wait_done("repeated start", 44 * Q, 32'h1, 0, 12'h0);
    checkOutput("repeated start seen", 32'(starts - s0), 32'd1);
    checkOutput("repeated start stops", 32'(stops - p0), 32'd1);

    // Reset at bit 4, q1 (tx bit 4 of 0xA0 is 0, so SDA is pulled)
    applyStimulus(12'h3A0, 1'b1, 8'hA0, 1'b0);
    repeat (17 * Q + 2) @(negedge clk);
    #1 check_lines("bit4 q1", 1'b0, 1'b1);
    rst = 1'b1;
    #1 check_lines("mid reset", 1'b0, 1'b0);
    checkOutput("mid reset status", data_out, 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(12'h3C3, 1'b1, 8'hC3, 1'b0);
    wait_done("post reset", 44 * Q, 32'h1, 0, 12'h0);
    check_lines("post reset released", 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Bus-attached I2C master; an IO device driven by the top-level address decoder through a per-device strobe.
- Occupies two consecutive IO words: addr=0 is data/command, addr=1 is status.
- Serves on-board I2C peripherals (sensors, EEPROM) alongside the SPI device.
- Drives open-drain SCL/SDA through pull-low enables; the pads and pull-ups live in the top level.

Parameters:
clock_freq, 50_000_000, system clock frequency in Hz
i2c_freq, 100_000, SCL frequency in Hz; quarter-period Q = clock_freq/(4*i2c_freq) cycles (125 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
stb  in  1  device strobe from address decoder
we  in  1  bus write enable
addr  in  1  word select (bus_addr[2])
data_in  in  32  bus write data
data_out  out  32  bus read data
ack  out  1  bus acknowledge
scl_drv  out  1  1 = pull SCL low, 0 = release
sda_drv  out  1  1 = pull SDA low, 0 = release
sda_in  in  1  sampled SDA pad level

Behaviour:
Reset (asynchronous, while rst=1): state IDLE; scl_drv=0, sda_drv=0; busy=0; rx_byte=0; nack=0; quarter counter=0.

Bus handshake:
- ack = stb, combinational; zero wait states for reads and writes.

Read data:
- addr=0: {23'b0, nack, rx_byte[7:0]}.
- addr=1: {30'b0, nack, busy}.

Command write (stb & we & addr=0):
- data_in[7:0] = tx byte; [8] = START before the byte; [9] = STOP after it; [10] = read (1) or write (0); [11] = master NACK on a read (1 = NACK, 0 = ACK).
- Accepted only when busy=0; a write while busy is ignored.
- An accepted command sets busy=1 in the next cycle.
- Writes to addr=1 are ignored.

Quarter timer:
- Counts 0..Q-1; each phase step is one quarter (Q cycles); restarts at 0 on each state entry.

FSM, states IDLE, START, BIT, STOP; quarters q0..q3:
- IDLE: on an accepted command go to START if [8]=1, else to BIT with bit index 7.
- START: q0 sda_drv=0; q1 scl_drv=0; q2 sda_drv=1; q3 scl_drv=1; then BIT. The same sequence serves both initial and repeated start.
- BIT, 9 bits (index 7..0, then the ack slot):
  - q0: set sda_drv while SCL is low. Write: sda_drv = ~tx[i]. Read: sda_drv=0. Ack slot: write releases (0); read drives ~cmd_nack.
  - q1: scl_drv=0.
  - q2: sample sda_in at the end of the quarter. Read data bits shift into rx_byte MSB-first. On a write, the ack slot sample goes to nack (1 = slave NACK). On a read, nack takes the value of cmd_nack.
  - q3: scl_drv=1.
- After the ack slot: go to STOP if [9]=1. Otherwise go to IDLE with busy=0, scl_drv=1 (SCL held low), sda_drv unchanged.
- STOP: q0 sda_drv=1; q1 scl_drv=0; q2 sda_drv=0; q3 go to IDLE, busy=0, both lines released.

Durations:
- A transfer is START 4Q + BIT 36Q + STOP 4Q.
- busy falls exactly 44Q cycles after the first cycle of START (full transfer at defaults: 5500 cycles).

Boundary conditions:
- A command without START issued from released idle is legal but not protocol-correct; no protection.
- No clock stretching and no arbitration; SCL is never sampled.
- Reset mid-transfer releases both lines immediately, clears busy, aborts the transfer.
- rx_byte and nack hold their values until the next transfer overwrites them.

Test Plan:
- Reset: assert rst mid-idle -> scl_drv=0, sda_drv=0, addr=1 read = 0, addr=0 read = 0.
- Write 0x3A0 (START|STOP, write byte 0xA0), slave ACKs -> SDA bit pattern 1010_0000 valid on SCL high. busy=1 next cycle and 0 after 5500 cycles. Status read = 0x1.
- Same transfer, sda_in held high in the ack slot -> nack=1, status read = 0x3, lines released after STOP.
- Read command 0x E00 (read|NACK|STOP, no START) following a START write; slave drives 0x5C -> addr=0 read = 0x15C. sda_drv=1 is never asserted during data bits; SDA is released in the ack slot.
- Second command written while busy=1 -> ignored; the transfer and timing are unchanged. A write with no STOP then START -> SCL stays low between commands and a repeated start occurs (SDA falls while SCL is high).
- rst asserted at BIT q1 of bit 4 -> both lines released in the same cycle, busy=0. A new command after reset completes normally.
